// File: rtl/fpu_issue_arbiter_if.sv
// Bundle of request, execution-unit, response and status signals for
// fpu_issue_arbiter.
//
//   Requesters  : reqValid, reqReady, reqOp, reqA, reqB (per requester, packed)
//   FP unit     : exValid, exOp, exA, exB (to unit); exResult, exFlags (from unit)
//   Responses   : rspValid, rspReady, rspResult, rspFlags (per requester, packed)
//   Status      : flagsAcc, flagsClr, issueCount, idle
//
// Modport slave is the arbiter side; modport master is the requester/unit side.
interface fpu_issue_arbiter_if #(
    parameter int unsigned NREQ = 4
);
    logic [NREQ-1:0]      reqValid;
    logic [NREQ-1:0]      reqReady;
    logic [2*NREQ-1:0]    reqOp;
    logic [16*NREQ-1:0]   reqA;
    logic [16*NREQ-1:0]   reqB;

    logic                 exValid;
    logic [1:0]           exOp;
    logic [15:0]          exA;
    logic [15:0]          exB;
    logic [15:0]          exResult;
    logic [2:0]           exFlags;

    logic [NREQ-1:0]      rspValid;
    logic [NREQ-1:0]      rspReady;
    logic [16*NREQ-1:0]   rspResult;
    logic [3*NREQ-1:0]    rspFlags;

    logic [2:0]           flagsAcc;
    logic                 flagsClr;
    logic [15:0]          issueCount;
    logic                 idle;

    modport slave (
        input  reqValid, reqOp, reqA, reqB,
        input  exResult, exFlags,
        input  rspReady, flagsClr,
        output reqReady,
        output exValid, exOp, exA, exB,
        output rspValid, rspResult, rspFlags,
        output flagsAcc, issueCount, idle
    );

    modport master (
        output reqValid, reqOp, reqA, reqB,
        output exResult, exFlags,
        output rspReady, flagsClr,
        input  reqReady,
        input  exValid, exOp, exA, exB,
        input  rspValid, rspResult, rspFlags,
        input  flagsAcc, issueCount, idle
    );
endinterface

// File: rtl/fpu_issue_arbiter.sv
// Round-robin issue arbiter sharing one fixed-latency FP16 add/sub/mul unit
// among NREQ requesters.
//
// Ports:
//   clock    - single clock, rising edge
//   reset_L  - synchronous, active-low reset
//   bus      - fpu_issue_arbiter_if.slave:
//                request grant (reqReady, combinational one-hot/zero),
//                registered issue to the unit (exValid/exOp/exA/exB),
//                unit result/flags return, per-requester response slots,
//                sticky flag accumulator, accept counter, idle status.
//
// Each accepted request (including reserved op 11) enters a LAT+1 deep tag
// pipe; when a tag leaves the last stage the unit output is captured into
// the originating requester's response slot. Reserved ops never reach the
// unit and return a canonical NaN with no flags.
module fpu_issue_arbiter #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned LAT  = 2
) (
    input  logic               clock,
    input  logic               reset_L,
    fpu_issue_arbiter_if.slave bus
);

    localparam int unsigned IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [15:0] QNAN = 16'h7E00;

    typedef struct packed {
        logic           valid;
        logic           illegal;
        logic [IDW-1:0] id;
    } tag_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [NREQ-1:0]    busy;
    logic [IDW-1:0]     rrPtr;
    tag_t               tagPipe [LAT+1];

    logic               exValidQ;
    logic [1:0]         exOpQ;
    logic [15:0]        exAQ;
    logic [15:0]        exBQ;

    logic [NREQ-1:0]    rspValidQ;
    logic [16*NREQ-1:0] rspResultQ;
    logic [3*NREQ-1:0]  rspFlagsQ;
    logic [2:0]         flagsAccQ;
    logic [15:0]        issueCountQ;

    // ------------------------------------------------------------------
    // Combinational arbitration
    // ------------------------------------------------------------------
    logic [NREQ-1:0]    eligible;
    logic [NREQ-1:0]    grant;
    logic [IDW-1:0]     gntIdx;
    logic [IDW-1:0]     rrNext;
    logic               accept;
    logic [1:0]         gntOp;
    logic [15:0]        gntA;
    logic [15:0]        gntB;
    logic               gntLegal;
    tag_t               newTag;

    assign eligible = bus.reqValid & ~busy;

    // Rotating-priority search starting at rrPtr. The candidate index is
    // reduced modulo NREQ by a single subtract since rrPtr < NREQ and
    // k < NREQ. No grant is ever presented while reset is asserted.
    always_comb begin
        int unsigned cand;
        grant  = '0;
        gntIdx = '0;
        cand   = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            cand = 32'(rrPtr) + k;
            if (cand >= NREQ) begin
                cand = cand - NREQ;
            end
            if (reset_L && (grant == '0) && eligible[cand]) begin
                grant[cand] = 1'b1;
                gntIdx      = IDW'(cand);
            end
        end
    end

    assign accept = |grant;
    assign rrNext = (gntIdx == IDW'(NREQ - 1)) ? '0 : gntIdx + 1'b1;

    // One-hot operand mux for the granted requester.
    always_comb begin
        gntOp = '0;
        gntA  = '0;
        gntB  = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                gntOp = bus.reqOp[2*i +: 2];
                gntA  = bus.reqA[16*i +: 16];
                gntB  = bus.reqB[16*i +: 16];
            end
        end
    end

    assign gntLegal = (gntOp != 2'b11);

    always_comb begin
        newTag         = '0;
        newTag.valid   = accept;
        newTag.illegal = accept && !gntLegal;
        newTag.id      = gntIdx;
    end

    // ------------------------------------------------------------------
    // Capture path (last tag-pipe stage lines up with the unit output)
    // ------------------------------------------------------------------
    tag_t               capTag;
    logic [NREQ-1:0]    capSet;
    logic [15:0]        capResult;
    logic [2:0]         capFlags;
    logic               capLegal;
    logic [NREQ-1:0]    rspFire;

    assign capTag    = tagPipe[LAT];
    assign capLegal  = capTag.valid && !capTag.illegal;
    assign capResult = capTag.illegal ? QNAN : bus.exResult;
    assign capFlags  = capTag.illegal ? 3'b000 : bus.exFlags;
    assign rspFire   = rspValidQ & bus.rspReady;

    always_comb begin
        capSet = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (capTag.valid && (capTag.id == IDW'(i))) begin
                capSet[i] = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Arbitration state, issue registers and tag pipe
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (!reset_L) begin
            busy     <= '0;
            rrPtr    <= '0;
            exValidQ <= 1'b0;
            exOpQ    <= '0;
            exAQ     <= '0;
            exBQ     <= '0;
            for (int unsigned k = 0; k <= LAT; k++) begin
                tagPipe[k] <= '0;
            end
        end else begin
            // Grant and retire can never hit the same requester in one
            // cycle: a requester with a full slot is still busy.
            busy <= (busy | grant) & ~rspFire;

            if (accept) begin
                rrPtr <= rrNext;
            end

            exValidQ <= accept && gntLegal;
            if (accept && gntLegal) begin
                exOpQ <= gntOp;
                exAQ  <= gntA;
                exBQ  <= gntB;
            end

            tagPipe[0] <= newTag;
            for (int unsigned k = 1; k <= LAT; k++) begin
                tagPipe[k] <= tagPipe[k-1];
            end
        end
    end

    // ------------------------------------------------------------------
    // Response slots, flag accumulator, accept counter
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (!reset_L) begin
            rspValidQ   <= '0;
            rspResultQ  <= '0;
            rspFlagsQ   <= '0;
            flagsAccQ   <= '0;
            issueCountQ <= '0;
        end else begin
            rspValidQ <= (rspValidQ & ~rspFire) | capSet;
            for (int unsigned i = 0; i < NREQ; i++) begin
                if (capSet[i]) begin
                    rspResultQ[16*i +: 16] <= capResult;
                    rspFlagsQ[3*i +: 3]    <= capFlags;
                end
            end

            // A clear coinciding with a capture keeps only the new flags.
            flagsAccQ <= (bus.flagsClr ? 3'b000 : flagsAccQ)
                       | (capLegal ? bus.exFlags : 3'b000);

            if (accept) begin
                issueCountQ <= issueCountQ + 16'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.reqReady   = grant;
    assign bus.exValid    = exValidQ;
    assign bus.exOp       = exOpQ;
    assign bus.exA        = exAQ;
    assign bus.exB        = exBQ;
    assign bus.rspValid   = rspValidQ;
    assign bus.rspResult  = rspResultQ;
    assign bus.rspFlags   = rspFlagsQ;
    assign bus.flagsAcc   = flagsAccQ;
    assign bus.issueCount = issueCountQ;
    assign bus.idle       = (busy == '0);

endmodule

// File: tb/tb_fpu_issue_arbiter.sv
// Directed self-checking bench for fpu_issue_arbiter (NREQ=4, LAT=2).
// A small behavioural model stands in for the FP unit: it samples the issue
// port on each rising edge and presents a result LAT cycles after the
// exValid cycle; when no valid op is in its pipe it drives junk (DEAD/111).
module tb_fpu_issue_arbiter;

    localparam int unsigned NREQ = 4;
    localparam int unsigned LAT  = 2;

    logic clock = 1'b0;
    logic reset_L;

    fpu_issue_arbiter_if #(.NREQ(NREQ)) bus ();

    fpu_issue_arbiter #(.NREQ(NREQ), .LAT(LAT)) dut (
        .clock   (clock),
        .reset_L (reset_L),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    // ---------------- FP unit model ----------------
    logic [2:0]  unitFlags;
    logic [19:0] unitPipe [LAT] = '{default: '0};

    function automatic logic [15:0] unitFn(input logic [1:0] op, input logic [15:0] a,
                                           input logic [15:0] b);
        if (op == 2'b00 && a == 16'h3C00 && b == 16'h4000) return 16'h4200;
        return a ^ {b[7:0], b[15:8]} ^ {14'd0, op};
    endfunction

    always @(posedge clock) begin
        unitPipe[0] <= {bus.exValid, unitFlags, unitFn(bus.exOp, bus.exA, bus.exB)};
        for (int k = 1; k < LAT; k++) unitPipe[k] <= unitPipe[k-1];
    end

    assign bus.exResult = unitPipe[LAT-1][19] ? unitPipe[LAT-1][15:0]  : 16'hDEAD;
    assign bus.exFlags  = unitPipe[LAT-1][19] ? unitPipe[LAT-1][18:16] : 3'b111;

    // ---------------- checking helpers ----------------
    int unsigned passed = 0;
    int unsigned failed = 0;
    int unsigned total  = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic setReq(input int unsigned idx, input logic [1:0] op,
                          input logic [15:0] a, input logic [15:0] b);
        bus.reqOp[2*idx +: 2]  = op;
        bus.reqA[16*idx +: 16] = a;
        bus.reqB[16*idx +: 16] = b;
    endtask

    function automatic logic [15:0] rspRes(input int unsigned idx);
        return bus.rspResult[16*idx +: 16];
    endfunction

    function automatic logic [2:0] rspFl(input int unsigned idx);
        return bus.rspFlags[3*idx +: 3];
    endfunction

    task automatic doReset();
        reset_L = 1'b0;
        tick();
        tick();
        reset_L = 1'b1;
    endtask

    // Issue one op on requester idx and advance to the cycle right after
    // its capture edge; flagsClr is optionally held in the capture cycle.
    task automatic runOp(input int unsigned idx, input logic [1:0] op, input logic [15:0] a,
                         input logic [15:0] b, input logic [2:0] fl, input logic clr);
        setReq(idx, op, a, b);
        unitFlags = fl;
        bus.reqValid = '0;
        bus.reqValid[idx] = 1'b1;
        tick();
        bus.reqValid = '0;
        tick();
        tick();
        bus.flagsClr = clr;
        tick();
        bus.flagsClr = 1'b0;
    endtask

    task automatic retire(input int unsigned idx);
        bus.rspReady = '0;
        bus.rspReady[idx] = 1'b1;
        tick();
        bus.rspReady = '0;
    endtask

    logic [1:0]  opT [NREQ] = '{2'b00, 2'b01, 2'b10, 2'b00};
    logic [15:0] aT  [NREQ] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    logic [15:0] bT  [NREQ] = '{16'h0102, 16'h0304, 16'h0506, 16'h0708};

    initial begin
        // ---------------- reset ----------------
        reset_L      = 1'b0;
        bus.reqValid = '1;
        bus.reqOp    = '0;
        bus.reqA     = '0;
        bus.reqB     = '0;
        bus.rspReady = '0;
        bus.flagsClr = 1'b0;
        unitFlags    = 3'b000;
        #1;
        check("rst_reqReady_comb", bus.reqReady, 4'b0000);
        tick(); tick(); tick();
        check("rst_reqReady", bus.reqReady, 4'b0000);
        check("rst_exValid", bus.exValid, 1'b0);
        check("rst_exOp", bus.exOp, 2'b00);
        check("rst_exA", bus.exA, 16'h0000);
        check("rst_exB", bus.exB, 16'h0000);
        check("rst_rspValid", bus.rspValid, 4'b0000);
        check("rst_rspResult", bus.rspResult, 64'h0);
        check("rst_rspFlags", bus.rspFlags, 12'h000);
        check("rst_flagsAcc", bus.flagsAcc, 3'b000);
        check("rst_issueCount", bus.issueCount, 16'd0);
        check("rst_idle", bus.idle, 1'b1);
        bus.reqValid = '0;
        reset_L      = 1'b1;

        // ---------------- single op ----------------
        setReq(0, 2'b00, 16'h3C00, 16'h4000);
        bus.reqValid = 4'b0001;
        #1;
        check("single_grant", bus.reqReady, 4'b0001);
        tick();                                   // edge 0: accept
        bus.reqValid = '0;
        check("single_exValid", bus.exValid, 1'b1);
        check("single_exOp", bus.exOp, 2'b00);
        check("single_exA", bus.exA, 16'h3C00);
        check("single_exB", bus.exB, 16'h4000);
        check("single_issueCount", bus.issueCount, 16'd1);
        check("single_busy", bus.idle, 1'b0);
        tick();                                   // cycle 2
        check("single_exValid_drop", bus.exValid, 1'b0);
        check("single_exA_hold", bus.exA, 16'h3C00);
        tick();                                   // cycle 3
        check("single_rsp_early", bus.rspValid, 4'b0000);
        tick();                                   // cycle 4
        check("single_rspValid", bus.rspValid, 4'b0001);
        check("single_rspResult", rspRes(0), 16'h4200);
        check("single_rspFlags", rspFl(0), 3'b000);
        retire(0);
        check("single_retired", bus.rspValid, 4'b0000);
        check("single_idle", bus.idle, 1'b1);

        // ---------------- round robin ----------------
        doReset();
        for (int unsigned i = 0; i < NREQ; i++) setReq(i, opT[i], aT[i], bT[i]);
        bus.rspReady = 4'b1111;
        bus.reqValid = 4'b1111;
        #1;
        check("rr_grant0", bus.reqReady, 4'b0001);
        tick();
        check("rr_grant1", bus.reqReady, 4'b0010);
        check("rr_exA0", bus.exA, aT[0]);
        tick();
        check("rr_grant2", bus.reqReady, 4'b0100);
        check("rr_exOp1", bus.exOp, opT[1]);
        tick();
        check("rr_grant3", bus.reqReady, 4'b1000);
        tick();
        check("rr_allbusy", bus.reqReady, 4'b0000);
        check("rr_rspValid0", bus.rspValid, 4'b0001);
        check("rr_rspResult0", rspRes(0), unitFn(opT[0], aT[0], bT[0]));
        check("rr_issueCount4", bus.issueCount, 16'd4);
        tick();
        check("rr_regrant0", bus.reqReady, 4'b0001);
        check("rr_rspValid1", bus.rspValid, 4'b0010);
        check("rr_rspResult1", rspRes(1), unitFn(opT[1], aT[1], bT[1]));
        bus.reqValid = '0;
        tick(); tick(); tick(); tick();
        check("rr_drain_idle", bus.idle, 1'b1);
        check("rr_drain_count", bus.issueCount, 16'd4);
        check("rr_drain_rsp", bus.rspValid, 4'b0000);

        // ---------------- backpressure on requester 1 ----------------
        doReset();
        bus.rspReady = 4'b1101;
        bus.reqValid = 4'b1111;
        #1;
        check("bp_g0", bus.reqReady, 4'b0001);
        tick();
        check("bp_g1", bus.reqReady, 4'b0010);
        tick();
        check("bp_g2", bus.reqReady, 4'b0100);
        tick();
        check("bp_g3", bus.reqReady, 4'b1000);
        tick();
        check("bp_c4_ready", bus.reqReady, 4'b0000);
        check("bp_c4_rsp", bus.rspValid, 4'b0001);
        tick();
        check("bp_c5_ready", bus.reqReady, 4'b0001);
        check("bp_c5_rsp", bus.rspValid, 4'b0010);
        tick();
        check("bp_c6_ready", bus.reqReady, 4'b0000);
        check("bp_c6_rsp", bus.rspValid, 4'b0110);
        tick();
        check("bp_c7_ready", bus.reqReady, 4'b0100);
        check("bp_c7_rsp", bus.rspValid, 4'b1010);
        tick();
        check("bp_c8_ready", bus.reqReady, 4'b1000);
        check("bp_c8_rsp", bus.rspValid, 4'b0010);
        tick();
        check("bp_c9_ready", bus.reqReady, 4'b0000);
        check("bp_c9_rsp", bus.rspValid, 4'b0011);
        check("bp_c9_hold1", rspRes(1), unitFn(opT[1], aT[1], bT[1]));
        tick();
        check("bp_c10_ready", bus.reqReady, 4'b0001);
        check("bp_c10_rsp", bus.rspValid, 4'b0010);
        check("bp_c10_count", bus.issueCount, 16'd7);
        bus.reqValid = '0;
        bus.rspReady = 4'b1111;
        tick(); tick(); tick(); tick(); tick();
        check("bp_drain_idle", bus.idle, 1'b1);
        bus.rspReady = '0;

        // ---------------- reserved op ----------------
        doReset();
        setReq(2, 2'b11, 16'h1234, 16'h5678);
        bus.reqValid = 4'b0100;
        #1;
        check("ill_grant", bus.reqReady, 4'b0100);
        tick();
        bus.reqValid = '0;
        check("ill_exValid", bus.exValid, 1'b0);
        check("ill_exA_hold", bus.exA, 16'h0000);
        check("ill_count", bus.issueCount, 16'd1);
        tick(); tick();
        check("ill_rsp_early", bus.rspValid, 4'b0000);
        tick();
        check("ill_rspValid", bus.rspValid, 4'b0100);
        check("ill_rspResult", rspRes(2), 16'h7E00);
        check("ill_rspFlags", rspFl(2), 3'b000);
        check("ill_flagsAcc", bus.flagsAcc, 3'b000);
        retire(2);
        check("ill_idle", bus.idle, 1'b1);

        // ---------------- flag accumulation ----------------
        doReset();
        runOp(0, 2'b00, 16'h3C00, 16'h4000, 3'b100, 1'b0);
        check("fl_rspFlags0", rspFl(0), 3'b100);
        check("fl_acc_100", bus.flagsAcc, 3'b100);
        retire(0);
        runOp(1, 2'b10, 16'h7BFF, 16'h0001, 3'b001, 1'b0);
        check("fl_rspFlags1", rspFl(1), 3'b001);
        check("fl_acc_101", bus.flagsAcc, 3'b101);
        retire(1);
        runOp(3, 2'b01, 16'h0400, 16'h03FF, 3'b010, 1'b1);
        check("fl_clr_with_capture", bus.flagsAcc, 3'b010);
        check("fl_rspResult3", rspRes(3), unitFn(2'b01, 16'h0400, 16'h03FF));
        retire(3);
        bus.flagsClr = 1'b1;
        tick();
        bus.flagsClr = 1'b0;
        check("fl_clr_alone", bus.flagsAcc, 3'b000);

        // ---------------- reset with ops in flight ----------------
        unitFlags = 3'b111;
        setReq(0, 2'b00, 16'h1000, 16'h2000);
        setReq(1, 2'b10, 16'h3000, 16'h4000);
        bus.reqValid = 4'b0011;
        tick();
        tick();
        check("inflight_count", bus.issueCount, 16'd5);
        bus.reqValid = '0;
        reset_L = 1'b0;
        tick(); tick();
        reset_L = 1'b1;
        tick(); tick(); tick(); tick();
        check("inflight_rspValid", bus.rspValid, 4'b0000);
        check("inflight_flagsAcc", bus.flagsAcc, 3'b000);
        check("inflight_idle", bus.idle, 1'b1);
        check("inflight_count_rst", bus.issueCount, 16'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
